// File: rtl/eu_responder.sv
// Performance-monitor command endpoint for one execution unit: decodes command
// frames, owns the event counter and config bit, and streams ack/report frames.
module eu_responder #(
   parameter int unsigned     AXIS_DIN_W = 8,
   parameter int unsigned     ID_W       = 8,
   parameter logic [ID_W-1:0] ID         = 8'h00,
   parameter int unsigned     CNT_W      = 32,
   parameter bit              ACK_ON_BC  = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic                  s_axis_tvalid_i,
   output logic                  s_axis_tready_o,
   input  logic                  s_axis_tlast_i,
   input  logic [AXIS_DIN_W-1:0] s_axis_tdata_i,
   output logic                  m_axis_tvalid_o,
   input  logic                  m_axis_tready_i,
   output logic                  m_axis_tlast_o,
   output logic [AXIS_DIN_W-1:0] m_axis_tdata_o,
   input  logic                  event_i,
   output logic                  cnt_en_o
);

   localparam int unsigned RESP_BYTES = 2 + CNT_W / 8;
   localparam logic [3:0]  ACK_LAST   = 4'd1;
   localparam logic [3:0]  REP_LAST   = 4'(RESP_BYTES - 1);
   localparam logic [7:0]  OP_WR      = 8'h01;
   localparam logic [7:0]  OP_SEND    = 8'h11;
   localparam logic [7:0]  RSP_ACK    = 8'h81;
   localparam logic [7:0]  RSP_REP    = 8'h91;
   localparam logic [7:0]  BC_ADDR    = 8'hFF;

   typedef enum logic {ST_RX, ST_TX} state_e;

   state_e           state_q, state_d;
   logic [1:0]       rx_cnt_q, rx_cnt_d;
   logic             id_hit_q, id_hit_d;
   logic             bc_hit_q, bc_hit_d;
   logic [7:0]       op_q, op_d;
   logic             cfg_en_q, cfg_en_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] snap_q, snap_d;
   logic             rep_q, rep_d;
   logic [3:0]       tx_idx_q, tx_idx_d;
   logic             s_tready_q, s_tready_d;
   logic             m_tvalid_q, m_tvalid_d;
   logic             m_tlast_q, m_tlast_d;
   logic [7:0]       m_tdata_q, m_tdata_d;

   logic rx_hs, tx_hs, dest_ok, need_ack, wr_exec, send_exec, clr;

   // NOTE: every _d gets its hold value first so no path through this block infers a latch.
   always_comb begin
      state_d    = state_q;
      rx_cnt_d   = rx_cnt_q;
      id_hit_d   = id_hit_q;
      bc_hit_d   = bc_hit_q;
      op_d       = op_q;
      cfg_en_d   = cfg_en_q;
      cnt_d      = cnt_q;
      snap_d     = snap_q;
      rep_d      = rep_q;
      tx_idx_d   = tx_idx_q;
      m_tvalid_d = m_tvalid_q;
      m_tlast_d  = m_tlast_q;
      m_tdata_d  = m_tdata_q;

      // s_tready_q is only ever high in RX, so it doubles as the state qualifier.
      rx_hs     = s_tready_q && s_axis_tvalid_i;
      tx_hs     = m_tvalid_q && m_axis_tready_i;
      dest_ok   = id_hit_q || bc_hit_q;
      need_ack  = id_hit_q || (ACK_ON_BC && bc_hit_q);
      wr_exec   = rx_hs && s_axis_tlast_i && (rx_cnt_q == 2'd2) && (op_q == OP_WR) && dest_ok;
      send_exec = rx_hs && s_axis_tlast_i && (rx_cnt_q == 2'd1)
                  && (s_axis_tdata_i == OP_SEND) && dest_ok;
      clr       = wr_exec && s_axis_tdata_i[1];

      if (clr) begin
         cnt_d = '0;
      end else if (event_i && cfg_en_q) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      if (rx_hs) begin
         if (rx_cnt_q == 2'd0) begin
            id_hit_d = (s_axis_tdata_i == ID);
            bc_hit_d = (s_axis_tdata_i == BC_ADDR);
         end
         if (rx_cnt_q == 2'd1) begin
            op_d = s_axis_tdata_i;
         end
         if (s_axis_tlast_i) begin
            rx_cnt_d = 2'd0;
         end else if (rx_cnt_q != 2'd3) begin
            rx_cnt_d = rx_cnt_q + 2'd1;
         end
      end

      if (wr_exec) begin
         cfg_en_d = s_axis_tdata_i[0];
      end

      if (send_exec || (wr_exec && need_ack)) begin
         state_d    = ST_TX;
         rep_d      = send_exec;
         snap_d     = cnt_q;
         tx_idx_d   = 4'd0;
         m_tvalid_d = 1'b1;
         m_tlast_d  = 1'b0;
         m_tdata_d  = ID;
      end

      if (state_q == ST_TX && tx_hs) begin
         if (m_tlast_q) begin
            state_d    = ST_RX;
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
            m_tdata_d  = 8'h00;
         end else begin
            tx_idx_d  = tx_idx_q + 4'd1;
            m_tlast_d = (tx_idx_d == (rep_q ? REP_LAST : ACK_LAST));
            if (tx_idx_q == 4'd0) begin
               m_tdata_d = rep_q ? RSP_REP : RSP_ACK;
            end else begin
               // Snapshot goes out LSB first; drop each byte once it has been accepted.
               if (tx_idx_q != 4'd1) begin
                  snap_d = snap_q >> 8;
               end
               m_tdata_d = snap_d[7:0];
            end
         end
      end

      s_tready_d = (state_d == ST_RX);
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q    <= ST_RX;
         rx_cnt_q   <= 2'd0;
         id_hit_q   <= 1'b0;
         bc_hit_q   <= 1'b0;
         op_q       <= 8'h00;
         cfg_en_q   <= 1'b0;
         cnt_q      <= '0;
         snap_q     <= '0;
         rep_q      <= 1'b0;
         tx_idx_q   <= 4'd0;
         s_tready_q <= 1'b0;
         m_tvalid_q <= 1'b0;
         m_tlast_q  <= 1'b0;
         m_tdata_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         rx_cnt_q   <= rx_cnt_d;
         id_hit_q   <= id_hit_d;
         bc_hit_q   <= bc_hit_d;
         op_q       <= op_d;
         cfg_en_q   <= cfg_en_d;
         cnt_q      <= cnt_d;
         snap_q     <= snap_d;
         rep_q      <= rep_d;
         tx_idx_q   <= tx_idx_d;
         s_tready_q <= s_tready_d;
         m_tvalid_q <= m_tvalid_d;
         m_tlast_q  <= m_tlast_d;
         m_tdata_q  <= m_tdata_d;
      end
   end

   assign s_axis_tready_o = s_tready_q;
   assign m_axis_tvalid_o = m_tvalid_q;
   assign m_axis_tlast_o  = m_tlast_q;
   assign m_axis_tdata_o  = m_tdata_q;
   assign cnt_en_o        = cfg_en_q;

endmodule

// File: tb/tb_eu_responder.sv
// Directed bench for eu_responder: two units on one command bus, one 32-bit
// non-acking unit (ID 05) and one 8-bit broadcast-acking unit (ID 06).
module tb_eu_responder;

   logic       clk = 1'b0;
   logic       reset_ni;
   logic       s_tvalid, s_tlast;
   logic [7:0] s_tdata;
   logic       ready_a, ready_b;
   logic       m_tvalid_a, m_tvalid_b, m_tready_a, m_tready_b;
   logic       m_tlast_a, m_tlast_b;
   logic [7:0] m_tdata_a, m_tdata_b;
   logic       event_a, event_b, cnt_en_a, cnt_en_b;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] exp_b [16];
   int         exp_len;

   always #5 clk = ~clk;

   eu_responder #(.ID(8'h05), .CNT_W(32), .ACK_ON_BC(1'b0)) dut_a (
      .clk_i(clk), .reset_ni(reset_ni),
      .s_axis_tvalid_i(s_tvalid), .s_axis_tready_o(ready_a),
      .s_axis_tlast_i(s_tlast), .s_axis_tdata_i(s_tdata),
      .m_axis_tvalid_o(m_tvalid_a), .m_axis_tready_i(m_tready_a),
      .m_axis_tlast_o(m_tlast_a), .m_axis_tdata_o(m_tdata_a),
      .event_i(event_a), .cnt_en_o(cnt_en_a)
   );

   eu_responder #(.ID(8'h06), .CNT_W(8), .ACK_ON_BC(1'b1)) dut_b (
      .clk_i(clk), .reset_ni(reset_ni),
      .s_axis_tvalid_i(s_tvalid), .s_axis_tready_o(ready_b),
      .s_axis_tlast_i(s_tlast), .s_axis_tdata_i(s_tdata),
      .m_axis_tvalid_o(m_tvalid_b), .m_axis_tready_i(m_tready_b),
      .m_axis_tlast_o(m_tlast_b), .m_axis_tdata_o(m_tdata_b),
      .event_i(event_b), .cnt_en_o(cnt_en_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Frame bytes are packed with byte0 most significant; ev_last 1/2 pulses A/B on the tlast byte.
   task automatic send(input int len, input logic [31:0] frame, input int ev_last);
      int guard;
      for (int i = 0; i < len; i++) begin
         guard = 0;
         while (!(ready_a && ready_b) && guard < 50) begin
            step();
            guard++;
         end
         if (guard == 50) check("send_ready_timeout", 32'({ready_a, ready_b}), 32'd3);
         s_tvalid = 1'b1;
         s_tdata  = 8'(frame >> (8 * (len - 1 - i)));
         s_tlast  = (i == len - 1);
         event_a  = (ev_last == 1) && (i == len - 1);
         event_b  = (ev_last == 2) && (i == len - 1);
         step();
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tdata  = 8'h00;
      event_a  = 1'b0;
      event_b  = 1'b0;
   endtask

   task automatic set_ack(input logic [7:0] id);
      exp_len  = 2;
      exp_b[0] = id;
      exp_b[1] = 8'h81;
   endtask

   task automatic set_rep(input logic [7:0] id, input int nbytes, input logic [31:0] val);
      exp_len  = 2 + nbytes;
      exp_b[0] = id;
      exp_b[1] = 8'h91;
      for (int k = 0; k < nbytes; k++) exp_b[2 + k] = 8'(val >> (8 * k));
   endtask

   task automatic pulse(input int which, input int n);
      for (int i = 0; i < n; i++) begin
         if (which == 0) event_a = 1'b1; else event_b = 1'b1;
         step();
         event_a = 1'b0;
         event_b = 1'b0;
         step();
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         check("drop_tvalid_a", 32'(m_tvalid_a), 32'd0);
         check("drop_tvalid_b", 32'(m_tvalid_b), 32'd0);
         check("drop_tready", 32'({ready_a, ready_b}), 32'd3);
         step();
      end
   endtask

   // Drains up to stop_after bytes from one unit; toggle gives a 1010 tready pattern,
   // ev_n pulses event_a on alternate cycles while the frame is in flight.
   task automatic collect(input int which, input int stop_after, input bit toggle, input int ev_n);
      int         hs;
      int         cyc;
      logic       stalled;
      logic [7:0] held;
      logic       rdy, tv, tl, str;
      logic [7:0] td;
      hs = 0;
      cyc = 0;
      stalled = 1'b0;
      held = 8'h00;
      while (hs < stop_after && cyc < 200) begin
         rdy = toggle ? ((cyc % 2) == 0) : 1'b1;
         tv  = (which == 0) ? m_tvalid_a : m_tvalid_b;
         tl  = (which == 0) ? m_tlast_a  : m_tlast_b;
         td  = (which == 0) ? m_tdata_a  : m_tdata_b;
         str = (which == 0) ? ready_a    : ready_b;
         check($sformatf("u%0d_tvalid_in_tx", which), 32'(tv), 32'd1);
         check($sformatf("u%0d_s_tready_in_tx", which), 32'(str), 32'd0);
         if (stalled) check($sformatf("u%0d_stall_hold", which), 32'(td), 32'(held));
         if (which == 0) m_tready_a = rdy; else m_tready_b = rdy;
         event_a = (cyc < 2 * ev_n) && ((cyc % 2) == 0);
         if (tv && rdy) begin
            check($sformatf("u%0d_byte%0d", which, hs), 32'(td), 32'(exp_b[hs]));
            check($sformatf("u%0d_tlast%0d", which, hs), 32'(tl), (hs == exp_len - 1) ? 32'd1 : 32'd0);
            hs++;
            stalled = 1'b0;
         end else begin
            stalled = tv;
            held    = td;
         end
         step();
         cyc++;
      end
      m_tready_a = 1'b0;
      m_tready_b = 1'b0;
      event_a    = 1'b0;
      if (hs < stop_after) check($sformatf("u%0d_resp_timeout", which), 32'(hs), 32'(stop_after));
      if (stop_after == exp_len) begin
         check($sformatf("u%0d_tvalid_after", which), 32'((which == 0) ? m_tvalid_a : m_tvalid_b), 32'd0);
         check($sformatf("u%0d_s_tready_after", which), 32'((which == 0) ? ready_a : ready_b), 32'd1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      reset_ni   = 1'b0;
      s_tvalid   = 1'b0;
      s_tlast    = 1'b0;
      s_tdata    = 8'h00;
      m_tready_a = 1'b0;
      m_tready_b = 1'b0;
      event_a    = 1'b0;
      event_b    = 1'b0;
      exp_len    = 0;
      repeat (3) step();

      // Reset values and tready rising one cycle after release.
      check("rst_outs_a", 32'({ready_a, m_tvalid_a, m_tlast_a, m_tdata_a, cnt_en_a}), 32'd0);
      check("rst_outs_b", 32'({ready_b, m_tvalid_b, m_tlast_b, m_tdata_b, cnt_en_b}), 32'd0);
      reset_ni = 1'b1;
      check("tready_before_edge", 32'(ready_a), 32'd0);
      step();
      check("tready_after_release", 32'({ready_a, ready_b}), 32'd3);

      // Addressed WR enables counting and is acked one cycle after tlast.
      send(3, 32'h050101, 0);
      check("wr_ack_latency", 32'(m_tvalid_a), 32'd1);
      check("wr_tready_drop", 32'(ready_a), 32'd0);
      check("wr_cnt_en_a", 32'(cnt_en_a), 32'd1);
      check("wr_b_silent", 32'(m_tvalid_b), 32'd0);
      set_ack(8'h05);
      collect(0, 2, 1'b0, 0);
      check("wr_cnt_en_b", 32'(cnt_en_b), 32'd0);

      // Ten events then an addressed report.
      pulse(0, 10);
      send(2, 32'h0511, 0);
      check("send_b_silent", 32'(m_tvalid_b), 32'd0);
      set_rep(8'h05, 4, 32'd10);
      collect(0, 6, 1'b0, 0);

      // Broadcast WR with clear: only the ACK_ON_BC unit answers.
      send(3, 32'hFF0103, 0);
      check("bc_a_no_ack", 32'(m_tvalid_a), 32'd0);
      check("bc_a_tready", 32'(ready_a), 32'd1);
      check("bc_b_ack", 32'(m_tvalid_b), 32'd1);
      check("bc_cnt_en", 32'({cnt_en_a, cnt_en_b}), 32'd3);
      set_ack(8'h06);
      collect(1, 2, 1'b0, 0);
      check("bc_a_still_silent", 32'(m_tvalid_a), 32'd0);

      // Broadcast SEND: both report zero, B waits stalled while A drains.
      send(2, 32'hFF11, 0);
      check("bcs_both_valid", 32'({m_tvalid_a, m_tvalid_b}), 32'd3);
      set_rep(8'h05, 4, 32'd0);
      collect(0, 6, 1'b0, 0);
      set_rep(8'h06, 1, 32'd0);
      collect(1, 3, 1'b0, 0);

      // Malformed or foreign frames are consumed silently.
      send(3, 32'h070100, 0);   idle(3);
      send(3, 32'h052200, 0);   idle(3);
      send(2, 32'h0501, 0);     idle(3);
      send(4, 32'h05010000, 0); idle(3);
      send(3, 32'h051100, 0);   idle(3);
      check("drop_cfg_kept", 32'({cnt_en_a, cnt_en_b}), 32'd3);

      // Event on the SEND tlast cycle is counted but not reported; events during a stalled report.
      pulse(0, 3);
      send(2, 32'h0511, 1);
      set_rep(8'h05, 4, 32'd3);
      collect(0, 6, 1'b1, 4);
      send(2, 32'h0511, 0);
      set_rep(8'h05, 4, 32'd8);
      collect(0, 6, 1'b0, 0);

      // 8-bit counter wrap.
      pulse(1, 255);
      send(2, 32'h0611, 0);
      set_rep(8'h06, 1, 32'hFF);
      collect(1, 3, 1'b0, 0);
      pulse(1, 1);
      send(2, 32'h0611, 0);
      set_rep(8'h06, 1, 32'h00);
      collect(1, 3, 1'b0, 0);

      // Clear beats a coincident event; counting stays enabled.
      pulse(1, 5);
      send(3, 32'h060103, 2);
      set_ack(8'h06);
      collect(1, 2, 1'b0, 0);
      check("clr_cnt_en_b", 32'(cnt_en_b), 32'd1);
      send(2, 32'h0611, 0);
      set_rep(8'h06, 1, 32'h00);
      collect(1, 3, 1'b0, 0);
      pulse(1, 1);
      send(2, 32'h0611, 0);
      set_rep(8'h06, 1, 32'h01);
      collect(1, 3, 1'b0, 0);

      // Reset in the middle of a report.
      send(2, 32'h0511, 0);
      set_rep(8'h05, 4, 32'd8);
      collect(0, 3, 1'b0, 0);
      reset_ni = 1'b0;
      step();
      check("midrst_outs_a", 32'({ready_a, m_tvalid_a, m_tlast_a, m_tdata_a, cnt_en_a}), 32'd0);
      check("midrst_outs_b", 32'({ready_b, m_tvalid_b, m_tlast_b, m_tdata_b, cnt_en_b}), 32'd0);
      reset_ni = 1'b1;
      check("midrst_tready_held", 32'(ready_a), 32'd0);
      step();
      check("midrst_tready_up", 32'({ready_a, ready_b}), 32'd3);
      pulse(0, 2);
      send(2, 32'h0511, 0);
      set_rep(8'h05, 4, 32'd0);
      collect(0, 6, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
